// File: rtl/inert_spi_resp.sv
// inert_spi_resp: SPI responder modelling the inertial sensor end of the
// pitch/AZ link. It decodes 16-bit mode-0 frames: the command byte comes first,
// then the data byte. Writes update a small configuration set. Reads return
// register data on the second byte of the same frame. New pitch-rate/AZ samples
// are presented through read-only registers, and INT flags a fresh sample.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   SS_n, SCLK      SPI select / clock from the master (asynchronous, synchronized here)
//   MOSI, MISO      SPI data in (MSB first) / data out
//   INT             sample-ready interrupt, active high
//   smpl_vld        1-clk strobe qualifying smpl_ptch_rt / smpl_AZ
//   smpl_ptch_rt    signed pitch-rate sample
//   smpl_AZ         signed Z-acceleration sample
//   init_done       high once 0x0D, 0x10, 0x11 and 0x14 have each been written
//
// Handshake: smpl_vld is a single-cycle strobe with no back-pressure. A strobe
// seen while a frame is active is parked and is applied right after SS_n rises,
// so the sample registers never change in the middle of a frame.
module inert_spi_resp #(
   parameter logic [7:0]  WHO_AM_I      = 8'h6A,
   parameter int unsigned MIN_SCLK_CLKS = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   output logic        INT,
   input  logic        smpl_vld,
   input  logic [15:0] smpl_ptch_rt,
   input  logic [15:0] smpl_AZ,
   output logic        init_done
);

   typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

   state_t      state_q, state_d;
   logic        ss_s1, ss_s2, ss_s3;
   logic        sclk_s1, sclk_s2, sclk_s3;
   logic        mosi_s1, mosi_s2;
   logic        ss_fall, ss_rise, sclk_rise, sclk_fall;
   logic [4:0]  bit_cnt;
   logic [15:0] rx;
   logic [7:0]  tx;
   logic        enter_data, cnt_en, commit, commit_wr, commit_rd22;
   logic [7:0]  int1_ctrl, ctrl1_xl, ctrl2_g, ctrl5;
   logic [3:0]  cfg_seen;
   logic [15:0] ptch_q, az_q, hold_ptch, hold_az;
   logic        smpl_pend, load_direct, smpl_load, load_q;
   logic [7:0]  half_cnt;

   // The third flop of each edge-detected input gives the previous synced value.
   assign ss_fall   =  ss_s3 & ~ss_s2;
   assign ss_rise   = ~ss_s3 &  ss_s2;
   assign sclk_rise =  sclk_s2 & ~sclk_s3;
   assign sclk_fall = ~sclk_s2 &  sclk_s3;

   // rx[7:0] holds the command byte after 8 rises. After 16 rises the command
   // has shifted up into rx[15:8], so commit decodes from the upper byte.
   assign enter_data  = (state_q == CMD) && (bit_cnt == 5'd8) && !ss_rise;
   assign cnt_en      = sclk_rise && (((state_q == CMD)  && (bit_cnt < 5'd8)) ||
                                      ((state_q == DATA) && (bit_cnt < 5'd16)));
   assign commit      = ss_rise && (bit_cnt == 5'd16);
   assign commit_wr   = commit && !rx[15];
   assign commit_rd22 = commit && rx[15] && (rx[14:8] == 7'h22);

   // A direct load takes priority over a parked sample: it is the newer one.
   assign load_direct = smpl_vld && ss_s2;
   assign smpl_load   = load_direct || (ss_rise && smpl_pend);

   assign MISO      = (state_q == DATA) ? tx[7] : 1'b0;
   assign init_done = &cfg_seen;

   function automatic logic [7:0] reg_rd(input logic [6:0] addr);
      case (addr)
         7'h0D:   reg_rd = int1_ctrl;
         7'h0F:   reg_rd = WHO_AM_I;
         7'h10:   reg_rd = ctrl1_xl;
         7'h11:   reg_rd = ctrl2_g;
         7'h14:   reg_rd = ctrl5;
         7'h22:   reg_rd = ptch_q[7:0];
         7'h23:   reg_rd = ptch_q[15:8];
         7'h2C:   reg_rd = az_q[7:0];
         7'h2D:   reg_rd = az_q[15:8];
         default: reg_rd = 8'h00;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      if (ss_rise) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (ss_fall) state_d = CMD;
            CMD:     if (bit_cnt == 5'd8) state_d = DATA;
            DATA:    if (bit_cnt == 5'd16) state_d = DONE;
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ss_s1   <= 1'b1;
         ss_s2   <= 1'b1;
         ss_s3   <= 1'b1;
         sclk_s1 <= 1'b0;
         sclk_s2 <= 1'b0;
         sclk_s3 <= 1'b0;
         mosi_s1 <= 1'b0;
         mosi_s2 <= 1'b0;
      end else begin
         state_q <= state_d;
         ss_s1   <= SS_n;
         ss_s2   <= ss_s1;
         ss_s3   <= ss_s2;
         sclk_s1 <= SCLK;
         sclk_s2 <= sclk_s1;
         sclk_s3 <= sclk_s2;
         mosi_s1 <= MOSI;
         mosi_s2 <= mosi_s1;
      end
   end

   // Frame shift/count datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt <= 5'd0;
         rx      <= 16'h0000;
         tx      <= 8'h00;
      end else begin
         if ((state_q == IDLE) && ss_fall) begin
            bit_cnt <= 5'd0;
         end else if (cnt_en) begin
            bit_cnt <= bit_cnt + 5'd1;
            rx      <= {rx[14:0], mosi_s2};
         end
         // Shifting only on falls after rise 9 keeps data[7] on MISO through rise 9.
         if (enter_data) begin
            tx <= rx[7] ? reg_rd(rx[6:0]) : 8'h00;
         end else if ((state_q == DATA) && sclk_fall && (bit_cnt >= 5'd9)) begin
            tx <= {tx[6:0], 1'b0};
         end
      end
   end

   // Configuration registers and the sticky init tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         int1_ctrl <= 8'h00;
         ctrl1_xl  <= 8'h00;
         ctrl2_g   <= 8'h00;
         ctrl5     <= 8'h00;
         cfg_seen  <= 4'b0000;
      end else if (commit_wr) begin
         case (rx[14:8])
            7'h0D: begin int1_ctrl <= rx[7:0]; cfg_seen[0] <= 1'b1; end
            7'h10: begin ctrl1_xl  <= rx[7:0]; cfg_seen[1] <= 1'b1; end
            7'h11: begin ctrl2_g   <= rx[7:0]; cfg_seen[2] <= 1'b1; end
            7'h14: begin ctrl5     <= rx[7:0]; cfg_seen[3] <= 1'b1; end
            default: ;
         endcase
      end
   end

   // Sample bank, mid-frame holding register and interrupt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptch_q    <= 16'h0000;
         az_q      <= 16'h0000;
         hold_ptch <= 16'h0000;
         hold_az   <= 16'h0000;
         smpl_pend <= 1'b0;
         load_q    <= 1'b0;
         INT       <= 1'b0;
      end else begin
         if (smpl_vld && !ss_s2) begin
            hold_ptch <= smpl_ptch_rt;
            hold_az   <= smpl_AZ;
            smpl_pend <= 1'b1;
         end else if (ss_rise) begin
            smpl_pend <= 1'b0;
         end
         if (load_direct) begin
            ptch_q <= smpl_ptch_rt;
            az_q   <= smpl_AZ;
         end else if (smpl_load) begin
            ptch_q <= hold_ptch;
            az_q   <= hold_az;
         end
         load_q <= smpl_load;
         // Set beats clear when both land in the same cycle.
         if (load_q && int1_ctrl[1] && (ctrl2_g[7:4] != 4'h0)) begin
            INT <= 1'b1;
         end else if (commit_rd22) begin
            INT <= 1'b0;
         end
      end
   end

   // Clocks spent since the last synced SCLK edge within a frame. The edge
   // detector can only follow SCLK when each half-period spans at least
   // MIN_SCLK_CLKS clocks (one clock of slack for synchronizer phase).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         half_cnt <= 8'd0;
      end else if (ss_s2 || sclk_rise || sclk_fall) begin
         half_cnt <= 8'd0;
      end else if (half_cnt != 8'hFF) begin
         half_cnt <= half_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && !ss_s2 && (sclk_rise || sclk_fall)) begin
         assert (32'(half_cnt) + 32'd1 >= MIN_SCLK_CLKS);
      end
   end

endmodule

// File: tb/tb_inert_spi_resp.sv
// Bench for inert_spi_resp: a vector table of whole SPI frames for the
// register map, then hand-written sequences for samples, INT, aborted frames
// and reset in the middle of a frame.
module tb_inert_spi_resp;

   localparam int HALF = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        SS_n = 1'b1;
   logic        SCLK = 1'b0;
   logic        MOSI = 1'b0;
   logic        MISO;
   logic        INT;
   logic        smpl_vld = 1'b0;
   logic [15:0] smpl_ptch_rt = 16'h0000;
   logic [15:0] smpl_AZ = 16'h0000;
   logic        init_done;

   int errors = 0;
   int checks = 0;
   int rise_cnt = 0;

   typedef struct {
      logic [15:0] word;
      logic [7:0]  exp_rd;
      logic        exp_int;
      logic        exp_init;
   } vec_t;

   vec_t vecs[13];

   inert_spi_resp dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .SS_n         (SS_n),
      .SCLK         (SCLK),
      .MOSI         (MOSI),
      .MISO         (MISO),
      .INT          (INT),
      .smpl_vld     (smpl_vld),
      .smpl_ptch_rt (smpl_ptch_rt),
      .smpl_AZ      (smpl_AZ),
      .init_done    (init_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Mode-0 master: MOSI set while SCLK low, MISO sampled just before each rise.
   task automatic spi_frame(input logic [15:0] word, input int n_rises, output logic [7:0] rd);
      rd = 8'h00;
      rise_cnt = 0;
      @(negedge clk);
      SS_n = 1'b0;
      wait_clks(HALF);
      for (int i = 0; i < n_rises; i++) begin
         MOSI = word[15 - i];
         wait_clks(HALF);
         if (i >= 8) rd[15 - i] = MISO;
         SCLK = 1'b1;
         rise_cnt++;
         wait_clks(HALF);
         SCLK = 1'b0;
      end
      MOSI = 1'b0;
      wait_clks(HALF);
      SS_n = 1'b1;
      wait_clks(HALF);
   endtask

   task automatic pulse_sample(input logic [15:0] p, input logic [15:0] a);
      @(negedge clk);
      smpl_vld     = 1'b1;
      smpl_ptch_rt = p;
      smpl_AZ      = a;
      @(negedge clk);
      smpl_vld = 1'b0;
   endtask

   task automatic read_chk(input string name, input logic [15:0] word, input logic [7:0] exp);
      logic [7:0] rd;
      spi_frame(word, 16, rd);
      check(name, {8'h00, rd}, {8'h00, exp});
   endtask

   initial begin
      logic [7:0] rd;
      int k;

      vecs[0]  = '{16'h8F00, 8'h6A, 1'b0, 1'b0};
      vecs[1]  = '{16'h0D02, 8'h00, 1'b0, 1'b0};
      vecs[2]  = '{16'h1053, 8'h00, 1'b0, 1'b0};
      vecs[3]  = '{16'h1150, 8'h00, 1'b0, 1'b0};
      vecs[4]  = '{16'h1460, 8'h00, 1'b0, 1'b1};
      vecs[5]  = '{16'h9100, 8'h50, 1'b0, 1'b1};
      vecs[6]  = '{16'h8D00, 8'h02, 1'b0, 1'b1};
      vecs[7]  = '{16'h9000, 8'h53, 1'b0, 1'b1};
      vecs[8]  = '{16'h9400, 8'h60, 1'b0, 1'b1};
      vecs[9]  = '{16'h0F12, 8'h00, 1'b0, 1'b1};
      vecs[10] = '{16'h8F00, 8'h6A, 1'b0, 1'b1};
      vecs[11] = '{16'h2255, 8'h00, 1'b0, 1'b1};
      vecs[12] = '{16'hA200, 8'h00, 1'b0, 1'b1};

      wait_clks(4);
      check("reset MISO", {15'd0, MISO}, 16'd0);
      check("reset INT", {15'd0, INT}, 16'd0);
      check("reset init_done", {15'd0, init_done}, 16'd0);
      rst_n = 1'b1;
      wait_clks(4);

      // Register map and init sequence.
      for (int i = 0; i < 13; i++) begin
         spi_frame(vecs[i].word, 16, rd);
         check($sformatf("vec%0d rd", i), {8'h00, rd}, {8'h00, vecs[i].exp_rd});
         check($sformatf("vec%0d INT", i), {15'd0, INT}, {15'd0, vecs[i].exp_int});
         check($sformatf("vec%0d init_done", i), {15'd0, init_done}, {15'd0, vecs[i].exp_init});
      end

      // Sample load and INT clear by a 0x22 read.
      pulse_sample(16'h1234, 16'hFEDC);
      wait_clks(3);
      check("smpl INT set", {15'd0, INT}, 16'd1);
      read_chk("rd 22", 16'hA200, 8'h34);
      check("INT clr after 22", {15'd0, INT}, 16'd0);
      read_chk("rd 2C", 16'hAC00, 8'hDC);
      read_chk("rd 2D", 16'hAD00, 8'hFE);

      // Sample arriving mid-frame is parked until SS_n rises.
      fork
         spi_frame(16'hA300, 16, rd);
         begin
            wait_clks(60);
            pulse_sample(16'h0055, 16'h0102);
         end
      join
      check("midframe rd 23 old", {8'h00, rd}, 16'h0012);
      check("midframe INT set", {15'd0, INT}, 16'd1);
      read_chk("rd 22 new", 16'hA200, 8'h55);
      check("INT clr again", {15'd0, INT}, 16'd0);
      read_chk("rd 2C new", 16'hAC00, 8'h02);
      read_chk("rd 2D new", 16'hAD00, 8'h01);

      // Aborted frames commit nothing and leave INT alone.
      pulse_sample(16'h1234, 16'hFEDC);
      wait_clks(3);
      check("INT set 2", {15'd0, INT}, 16'd1);
      spi_frame(16'h1077, 10, rd);
      check("abort wr INT", {15'd0, INT}, 16'd1);
      spi_frame(16'hA200, 10, rd);
      check("abort rd22 INT", {15'd0, INT}, 16'd1);
      read_chk("ctrl1 unchanged", 16'h9000, 8'h53);
      check("INT after rd 10", {15'd0, INT}, 16'd1);
      read_chk("rd 23 full", 16'hA300, 8'h12);
      read_chk("rd 22 full", 16'hA200, 8'h34);
      check("INT clr 3", {15'd0, INT}, 16'd0);

      // With INT1_CTRL[1] cleared a sample does not raise INT.
      spi_frame(16'h0D00, 16, rd);
      pulse_sample(16'h0777, 16'h0000);
      wait_clks(3);
      check("INT disabled", {15'd0, INT}, 16'd0);
      read_chk("rd 22 disabled", 16'hA200, 8'h77);

      // Make INT high, then reset during bit 12 of a write frame.
      spi_frame(16'h0D02, 16, rd);
      pulse_sample(16'h1111, 16'h2222);
      wait_clks(3);
      check("INT before reset", {15'd0, INT}, 16'd1);
      fork
         spi_frame(16'h0D02, 16, rd);
         begin
            k = 0;
            while (rise_cnt < 12 && k < 2000) begin
               wait_clks(1);
               k++;
            end
            check("reach rise 12", {15'd0, k < 2000}, 16'd1);
            wait_clks(3);
            rst_n = 1'b0;
            wait_clks(2);
            check("midrst MISO", {15'd0, MISO}, 16'd0);
            check("midrst INT", {15'd0, INT}, 16'd0);
            check("midrst init_done", {15'd0, init_done}, 16'd0);
         end
      join
      wait_clks(4);
      rst_n = 1'b1;
      wait_clks(4);
      check("post rst init_done", {15'd0, init_done}, 16'd0);
      read_chk("post rst int1", 16'h8D00, 8'h00);
      spi_frame(16'h0D02, 16, rd);
      read_chk("post rst int1 wr", 16'h8D00, 8'h02);
      check("post rst INT", {15'd0, INT}, 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
